// File: rtl/hazard_ctrl.sv
// hazard_ctrl: E/M/W write scoreboard that drives the D-stage stall and the operand forward selects.
// Build option HAZARD_FWD_EN enables forwarding; without it, any E/M producer match stalls.
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_rs_tuse,
  input  logic [1:0]  D_rt_tuse,
  input  logic [4:0]  D_wa,
  input  logic [1:0]  D_tnew,
  output logic        stall,
  output logic [1:0]  fwd_rs_sel,
  output logic [1:0]  fwd_rt_sel,
  output logic [15:0] stall_cnt
);

  typedef struct packed {
    logic [4:0] wa;
    logic [1:0] tnew;
  } sb_entry_t;

  sb_entry_t   e_q, m_q, w_q;
  logic [15:0] cnt_q;

  // Register $0 is never a real producer, so wa=0 entries never match.
  function automatic logic hit(input sb_entry_t x, input logic [4:0] r);
    return (x.wa != 5'd0) && (x.wa == r);
  endfunction

  function automatic logic [1:0] dec_sat(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= stall ? sb_entry_t'('0) : sb_entry_t'({D_wa, D_tnew});
      m_q <= sb_entry_t'({e_q.wa, dec_sat(e_q.tnew)});
      w_q <= sb_entry_t'({m_q.wa, dec_sat(m_q.tnew)});
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else if (stall && (cnt_q != 16'hFFFF))
      cnt_q <= cnt_q + 16'd1;
  end

  assign stall_cnt = cnt_q;

`ifdef HAZARD_FWD_EN
  logic unused_w_tnew;
  assign unused_w_tnew = ^w_q.tnew;

  function automatic logic op_stall(input sb_entry_t e, input sb_entry_t m,
                                    input logic [4:0] r, input logic [1:0] tuse);
    return (hit(e, r) && (e.tnew > tuse)) || (hit(m, r) && (m.tnew > tuse));
  endfunction

  // The youngest matching stage wins; if it is not ready yet, nothing older may be used.
  function automatic logic [1:0] op_sel(input sb_entry_t e, input sb_entry_t m,
                                        input sb_entry_t w, input logic [4:0] r);
    logic [1:0] sel;
    sel = 2'd0;
    if (hit(e, r))
      sel = (e.tnew == 2'd0) ? 2'd1 : 2'd0;
    else if (hit(m, r))
      sel = (m.tnew == 2'd0) ? 2'd2 : 2'd0;
    else if (hit(w, r))
      sel = 2'd3;
    return sel;
  endfunction

  always_comb begin
    stall      = op_stall(e_q, m_q, D_rs, D_rs_tuse) | op_stall(e_q, m_q, D_rt, D_rt_tuse);
    fwd_rs_sel = op_sel(e_q, m_q, w_q, D_rs);
    fwd_rt_sel = op_sel(e_q, m_q, w_q, D_rt);
  end
`else
  logic unused_nofwd;
  assign unused_nofwd = ^{D_rs_tuse, D_rt_tuse, w_q};

  // W never stalls: the register file writes in the first half-cycle.
  always_comb begin
    stall      = hit(e_q, D_rs) | hit(m_q, D_rs) | hit(e_q, D_rt) | hit(m_q, D_rt);
    fwd_rs_sel = 2'd0;
    fwd_rt_sel = 2'd0;
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random stimulus against an issue-time reference model, with a queue scoreboard.
// Follows the DUT build: define HAZARD_FWD_EN for both or neither.
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  D_rs, D_rt, D_wa;
  logic [1:0]  D_rs_tuse, D_rt_tuse, D_tnew;
  logic        stall;
  logic [1:0]  fwd_rs_sel, fwd_rt_sel;
  logic [15:0] stall_cnt;

  hazard_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .D_rs       (D_rs),
    .D_rt       (D_rt),
    .D_rs_tuse  (D_rs_tuse),
    .D_rt_tuse  (D_rt_tuse),
    .D_wa       (D_wa),
    .D_tnew     (D_tnew),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int wa;
    int tnew;
    int enter;
  } prod_t;

  typedef struct {
    logic        stall;
    logic [1:0]  rs_sel;
    logic [1:0]  rt_sel;
    logic [15:0] cnt;
  } exp_t;

  // Model: every issued producer remembers the cycle it entered E; its age gives its stage.
  prod_t       prod[$];
  exp_t        exp_q[$];
  int          cyc = 0;
  logic [15:0] m_cnt = 16'd0;
  int          total = 0;
  int          bad = 0;
  event        sample_ev;

  function automatic void model_op(input logic [4:0] r, input logic [1:0] tuse,
                                   output logic st, output logic [1:0] sel);
`ifdef HAZARD_FWD_EN
    bit found;
    int rem;
    found = 1'b0;
`endif
    st  = 1'b0;
    sel = 2'd0;
    for (int age = 0; age <= 2; age++) begin
      foreach (prod[i]) begin
        if (prod[i].enter == cyc - age && r != 5'd0 && prod[i].wa == int'(r)) begin
`ifdef HAZARD_FWD_EN
          rem = prod[i].tnew - age;
          if (rem < 0) rem = 0;
          if (age < 2 && rem > int'(tuse)) st = 1'b1;
          if (!found) begin
            found = 1'b1;
            if (age == 2)      sel = 2'd3;
            else if (rem == 0) sel = (age == 0) ? 2'd1 : 2'd2;
          end
`else
          if (age < 2) st = 1'b1;
`endif
        end
      end
    end
  endfunction

  task automatic applyStimulus(input logic rst, input logic chk,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [1:0] rs_tu, input logic [1:0] rt_tu,
                               input logic [4:0] wa, input logic [1:0] tn);
    exp_t       e;
    logic       st_a, st_b;
    logic [1:0] sel_a, sel_b;
    @(negedge clk);
    reset = rst; D_rs = rs; D_rt = rt; D_rs_tuse = rs_tu; D_rt_tuse = rt_tu;
    D_wa = wa; D_tnew = tn;
    model_op(rs, rs_tu, st_a, sel_a);
    model_op(rt, rt_tu, st_b, sel_b);
    e.stall  = st_a | st_b;
    e.rs_sel = sel_a;
    e.rt_sel = sel_b;
    e.cnt    = m_cnt;
    #2;
    if (chk) begin
      exp_q.push_back(e);
      -> sample_ev;
    end
    if (rst) begin
      prod.delete();
      m_cnt = 16'd0;
    end else begin
      if (!e.stall && wa != 5'd0)
        prod.push_back('{wa: int'(wa), tnew: int'(tn), enter: cyc + 1});
      if (e.stall && m_cnt != 16'hFFFF)
        m_cnt = m_cnt + 16'd1;
    end
    cyc++;
    while (prod.size() > 0 && prod[0].enter < cyc - 2) void'(prod.pop_front());
  endtask

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h (check %0d)", name, act, req, total);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_underflow: got=empty want=entry");
    end else begin
      e = exp_q.pop_front();
      cmp("stall", 16'(stall), 16'(e.stall));
      cmp("fwd_rs_sel", 16'(fwd_rs_sel), 16'(e.rs_sel));
      cmp("fwd_rt_sel", 16'(fwd_rt_sel), 16'(e.rt_sel));
      cmp("stall_cnt", stall_cnt, e.cnt);
    end
  endtask

  initial begin
    forever begin
      @(sample_ev);
      checkOutput();
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
  endtask

  task automatic load_use_burst(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd7, 2'd2);
      for (int j = 0; j < 3; j++) applyStimulus(1'b0, 1'b1, 5'd7, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
    end
  endtask

  initial begin
    reset = 1'b1; D_rs = '0; D_rt = '0; D_rs_tuse = '0; D_rt_tuse = '0; D_wa = '0; D_tnew = '0;

    // Reset with a producer on the D inputs; the first cycle is unchecked while state is unknown.
    applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 2'd0, 2'd0, 5'd5, 2'd2);
    applyStimulus(1'b1, 1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd5, 2'd2);
    idle(1);

    // Load-use
    applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd8, 2'd2);
    for (int j = 0; j < 3; j++) applyStimulus(1'b0, 1'b1, 5'd8, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
    idle(3);

    // ALU back-to-back
    applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd9, 2'd1);
    applyStimulus(1'b0, 1'b1, 5'd0, 5'd9, 2'd0, 2'd1, 5'd0, 2'd0);
    for (int j = 0; j < 3; j++) applyStimulus(1'b0, 1'b1, 5'd0, 5'd9, 2'd0, 2'd0, 5'd0, 2'd0);
    idle(3);

    // Priority: same register in E, M and W
    for (int j = 0; j < 3; j++) applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd4, 2'd0);
    applyStimulus(1'b0, 1'b1, 5'd4, 5'd4, 2'd0, 2'd0, 5'd0, 2'd0);
    idle(3);
    for (int j = 0; j < 2; j++) applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd4, 2'd0);
    applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd4, 2'd1);
    for (int j = 0; j < 2; j++) applyStimulus(1'b0, 1'b1, 5'd4, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
    idle(3);

    // $0 immunity
    applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd2);
    applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
    idle(3);

    // Saturation: preload the counter just below the limit, then keep stalling
    #1;
    force dut.cnt_q = 16'hFFFC;
    #1;
    release dut.cnt_q;
    m_cnt = 16'hFFFC;
    load_use_burst(4);

    // Reset asserted in the middle of a load-use stall
    applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd7, 2'd2);
    applyStimulus(1'b0, 1'b1, 5'd7, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
    applyStimulus(1'b1, 1'b1, 5'd7, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
    applyStimulus(1'b0, 1'b1, 5'd7, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
    idle(2);

    // Random traffic over a small register window so hazards are frequent
    for (int n = 0; n < 1500; n++) begin
      applyStimulus(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0, 1'b1,
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    @(negedge clk);
    #3;
    cmp("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
